dfe_coeff_sched: RTL

- Coefficient load scheduler for the DFE filter chain: fractional decimator, plus three IIR notch filters at 1 MHz, 2 MHz and 2.4 MHz.
- Accepts coefficient words one at a time from the register bus side and assembles them in per-filter shadow banks.
- Commits each completed bank atomically to its filter, only on an idle-sample cycle, using a one-cycle write-enable pulse with the full coefficient vector.
- Arbitrates between filters with pending commits and reports load errors. Sits between the APB slave and the core filter coefficient inputs.

---
 rtl/dfe_coeff_pkg.sv | 11 +
 rtl/dfe_coeff_bank.sv | 59 +++++
 rtl/dfe_coeff_sched.sv | 95 +++++++++
 3 files changed

// File: rtl/dfe_coeff_pkg.sv
// dfe_coeff_pkg: shared types and depth constants for the DFE coefficient load scheduler.
package dfe_coeff_pkg;
    localparam int DEF_COEFF_WIDTH = 20;
    localparam int DEF_IDX_WIDTH   = 7;
    localparam int DEPTH_FRAC      = 72;
    localparam int DEPTH_IIR       = 5;

    typedef enum logic [1:0] {TGT_FRAC, TGT_IIR1, TGT_IIR2, TGT_IIR24} tgt_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_IDX, ERR_CNT, ERR_ILV} err_e;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PEND} bank_st_e;
endpackage

// File: rtl/dfe_coeff_bank.sv
// dfe_coeff_bank: per-target shadow coefficient bank with word counter and IDLE/LOAD/PEND FSM.
module dfe_coeff_bank
    import dfe_coeff_pkg::*;
#(
    parameter int DEPTH = DEPTH_IIR,
    parameter int CW    = DEF_COEFF_WIDTH,
    parameter int IW    = DEF_IDX_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      take,
    input  logic                      last,
    input  logic                      abort,
    input  logic                      commit,
    input  logic [IW-1:0]             idx,
    input  logic [CW-1:0]             data,
    output logic [DEPTH-1:0][CW-1:0]  coeff,
    output logic                      pend,
    output logic                      busy,
    output logic                      cnt_err
);
    bank_st_e    st, st_n;
    logic [IW:0] cnt, cnt_n;
    logic        done, full;

    // Count including the word being accepted now; a fresh load starts at one.
    assign cnt_n = (st == ST_LOAD) ? cnt + (IW+1)'(1) : (IW+1)'(1);
    assign done  = take && last;
    assign full  = cnt_n == (IW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_n;
    end

    always_comb begin
        st_n = (st == ST_PEND) ? (commit ? ST_IDLE : ST_PEND) :
               abort           ? ST_IDLE :
               done            ? (full ? ST_PEND : ST_IDLE) :
               take            ? ST_LOAD : st;
    end

    always_comb begin
        pend    = st == ST_PEND;
        busy    = st == ST_LOAD;
        cnt_err = done && !full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            coeff <= '0;
        end else begin
            cnt <= (st_n != ST_LOAD) ? '0 : take ? cnt_n : cnt;
            for (int i = 0; i < DEPTH; i++)
                if (take && idx == IW'(i)) coeff[i] <= data;
        end
    end
endmodule

// File: rtl/dfe_coeff_sched.sv
// dfe_coeff_sched: coefficient load scheduler for the frac decimator and three IIR notches;
// owns load arbitration, the sticky error register and the fixed-priority commit arbiter.
module dfe_coeff_sched
    import dfe_coeff_pkg::*;
#(
    parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
    parameter int N_TAP       = DEPTH_FRAC,
    parameter int NUM_DENUM   = DEPTH_IIR,
    parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [1:0]                            cfg_target,
    input  logic [IDX_WIDTH-1:0]                  cfg_index,
    input  logic [COEFF_WIDTH-1:0]                cfg_data,
    input  logic                                  cfg_last,
    input  logic                                  sample_valid,
    output logic                                  frac_wr_en,
    output logic [N_TAP-1:0][COEFF_WIDTH-1:0]     frac_coeff,
    output logic                                  iir1_wr_en,
    output logic                                  iir2_wr_en,
    output logic                                  iir24_wr_en,
    output logic [NUM_DENUM-1:0][COEFF_WIDTH-1:0] iir1_coeff,
    output logic [NUM_DENUM-1:0][COEFF_WIDTH-1:0] iir2_coeff,
    output logic [NUM_DENUM-1:0][COEFF_WIDTH-1:0] iir24_coeff,
    output logic [3:0]                            pending,
    output logic                                  loading,
    output logic                                  err,
    output logic [1:0]                            err_code,
    input  logic                                  err_clr
);
    logic             acc, idx_bad;
    logic [IDX_WIDTH:0] depth;
    logic [3:0]       take, abort, commit, busy, cnt_err;
    err_e             err_new;

    assign cfg_ready = !pending[cfg_target];
    assign acc       = cfg_valid && cfg_ready;
    assign depth     = (cfg_target == TGT_FRAC) ? (IDX_WIDTH+1)'(N_TAP) : (IDX_WIDTH+1)'(NUM_DENUM);
    assign idx_bad   = {1'b0, cfg_index} >= depth;
    assign loading   = |busy;

    // An out-of-range word is dropped but still counts as a foreign word for ownership.
    always_comb begin
        take  = '0;
        abort = '0;
        for (int i = 0; i < 4; i++) begin
            take[i]  = acc && !idx_bad && cfg_target == 2'(i);
            abort[i] = acc && cfg_target != 2'(i);
        end
    end

    // Lowest set pending bit wins: frac > iir1 > iir2 > iir24.
    assign commit = sample_valid ? 4'b0 : pending & (~pending + 4'd1);
    assign {iir24_wr_en, iir2_wr_en, iir1_wr_en, frac_wr_en} = commit;

    assign err_new = |(abort & busy)   ? ERR_ILV :
                     |cnt_err          ? ERR_CNT :
                     (acc && idx_bad)  ? ERR_IDX : ERR_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (err_new != ERR_NONE) begin
            err      <= 1'b1;
            err_code <= err_new;
        end else if (err_clr) begin
            err      <= 1'b0;
            err_code <= 2'd0;
        end
    end

    dfe_coeff_bank #(.DEPTH(N_TAP), .CW(COEFF_WIDTH), .IW(IDX_WIDTH)) u_frac (
        .clk(clk), .rst_n(rst_n), .take(take[0]), .last(cfg_last), .abort(abort[0]),
        .commit(commit[0]), .idx(cfg_index), .data(cfg_data), .coeff(frac_coeff),
        .pend(pending[0]), .busy(busy[0]), .cnt_err(cnt_err[0]));

    dfe_coeff_bank #(.DEPTH(NUM_DENUM), .CW(COEFF_WIDTH), .IW(IDX_WIDTH)) u_iir1 (
        .clk(clk), .rst_n(rst_n), .take(take[1]), .last(cfg_last), .abort(abort[1]),
        .commit(commit[1]), .idx(cfg_index), .data(cfg_data), .coeff(iir1_coeff),
        .pend(pending[1]), .busy(busy[1]), .cnt_err(cnt_err[1]));

    dfe_coeff_bank #(.DEPTH(NUM_DENUM), .CW(COEFF_WIDTH), .IW(IDX_WIDTH)) u_iir2 (
        .clk(clk), .rst_n(rst_n), .take(take[2]), .last(cfg_last), .abort(abort[2]),
        .commit(commit[2]), .idx(cfg_index), .data(cfg_data), .coeff(iir2_coeff),
        .pend(pending[2]), .busy(busy[2]), .cnt_err(cnt_err[2]));

    dfe_coeff_bank #(.DEPTH(NUM_DENUM), .CW(COEFF_WIDTH), .IW(IDX_WIDTH)) u_iir24 (
        .clk(clk), .rst_n(rst_n), .take(take[3]), .last(cfg_last), .abort(abort[3]),
        .commit(commit[3]), .idx(cfg_index), .data(cfg_data), .coeff(iir24_coeff),
        .pend(pending[3]), .busy(busy[3]), .cnt_err(cnt_err[3]));
endmodule
